// File: rtl/col_addr_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// col_pkg : mode encodings and clog2 helper for the column-address dispatcher
// Revision 1.0
// ============================================================================
package col_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'd0;
  localparam logic [1:0] MODE_RR     = 2'd1;
  localparam logic [1:0] MODE_BCAST  = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  // Never returns less than 1 so a pointer port always has at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/col_addr_dispatch_if.sv
`default_nettype none
// ============================================================================
// col_addr_dispatch_if : producer handshake and slot-side bus of the dispatcher
// Revision 1.0
// ============================================================================
interface col_addr_dispatch_if #(
  parameter int COL_ADDR_WIDTH = 2560,
  parameter int NUM_CH         = 4,
  parameter int CTRL_WIDTH     = 3
);
  import col_pkg::*;

  localparam int PTR_WIDTH = clog2(NUM_CH);

  logic [COL_ADDR_WIDTH-1:0]        col_addr_in;
  logic                             in_valid;
  logic                             in_ready;
  logic [1:0]                       mode;
  logic [CTRL_WIDTH-1:0]            control;
  logic                             flush;
  logic [NUM_CH-1:0]                col_ack;
  logic [NUM_CH*COL_ADDR_WIDTH-1:0] col_addr_out;
  logic [NUM_CH-1:0]                col_valid;
  logic [PTR_WIDTH-1:0]             rr_ptr;
  logic                             sel_err;

  modport master (
    output col_addr_in, in_valid, mode, control, flush, col_ack,
    input  in_ready, col_addr_out, col_valid, rr_ptr, sel_err
  );

  modport slave (
    input  col_addr_in, in_valid, mode, control, flush, col_ack,
    output in_ready, col_addr_out, col_valid, rr_ptr, sel_err
  );

endinterface
`default_nettype wire

// File: rtl/col_addr_dispatch_slot.sv
`default_nettype none
// ============================================================================
// col_addr_slot : one holding slot (data register plus consumer valid flag)
// Revision 1.0
// ============================================================================
module col_addr_slot #(
  parameter int WIDTH = 2560
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             load,
  input  wire logic             ack,
  input  wire logic             flush,
  input  wire logic [WIDTH-1:0] data_in,
  output logic      [WIDTH-1:0] data,
  output logic                  valid
);

  // Flush wins over everything; a load in the same cycle as an ack keeps valid high.
  always_ff @(posedge clock) begin
    if (reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      data  <= data_in;
      valid <= 1'b1;
    end else if (ack) begin
      valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/col_addr_dispatch.sv
`default_nettype none
// ============================================================================
// col_addr_dispatch : steers column-address words into NUM_CH acked slots
// Revision 1.0
// ============================================================================
module col_addr_dispatch
  import col_pkg::*;
#(
  parameter int COL_ADDR_WIDTH = 2560,
  parameter int NUM_CH         = 4,
  parameter int CTRL_WIDTH     = 3
) (
  input wire logic      clock,
  input wire logic      reset,
  col_addr_dispatch_if.slave bus
);

  localparam int PTR_WIDTH = clog2(NUM_CH);

  logic [NUM_CH-1:0]                slot_valid;
  logic [NUM_CH*COL_ADDR_WIDTH-1:0] slot_data;
  logic [NUM_CH-1:0]                free;
  logic [NUM_CH-1:0]                load;
  logic                             in_range;
  logic                             dir_free;
  logic                             rr_free;
  logic                             ready;
  logic                             xfer;
  logic [PTR_WIDTH-1:0]             rr_ptr_q;
  logic                             sel_err_q;

  // An ack arriving this cycle frees the slot for an immediate refill.
  assign free = ~slot_valid | bus.col_ack;

  always_comb begin
    in_range = (int'(bus.control) >= 1) && (int'(bus.control) <= NUM_CH);
    dir_free = 1'b0;
    rr_free  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(bus.control) == i + 1) dir_free = free[i];
      if (int'(rr_ptr_q) == i)        rr_free  = free[i];
    end

    ready = 1'b0;
    case (bus.mode)
      MODE_DIRECT: ready = in_range ? dir_free : 1'b1;
      MODE_RR:     ready = rr_free;
      MODE_BCAST:  ready = &free;
      default:     ready = 1'b0;
    endcase
    if (reset || bus.flush) ready = 1'b0;
  end

  assign xfer = bus.in_valid & ready;

  always_comb begin
    load = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (bus.mode)
        MODE_DIRECT: load[i] = xfer & in_range & (int'(bus.control) == i + 1);
        MODE_RR:     load[i] = xfer & (int'(rr_ptr_q) == i);
        MODE_BCAST:  load[i] = xfer;
        default:     load[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= xfer & (bus.mode == MODE_DIRECT) & ~in_range;
      if (xfer && (bus.mode == MODE_RR)) begin
        rr_ptr_q <= (int'(rr_ptr_q) == NUM_CH - 1) ? '0 : rr_ptr_q + 1'b1;
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
      col_addr_slot #(
        .WIDTH (COL_ADDR_WIDTH)
      ) u_slot (
        .clock   (clock),
        .reset   (reset),
        .load    (load[g]),
        .ack     (bus.col_ack[g]),
        .flush   (bus.flush),
        .data_in (bus.col_addr_in),
        .data    (slot_data[g*COL_ADDR_WIDTH +: COL_ADDR_WIDTH]),
        .valid   (slot_valid[g])
      );
    end
  endgenerate

  assign bus.in_ready     = ready;
  assign bus.col_addr_out = slot_data;
  assign bus.col_valid    = slot_valid;
  assign bus.rr_ptr       = rr_ptr_q;
  assign bus.sel_err      = sel_err_q;

endmodule
`default_nettype wire

// File: tb/tb_col_addr_dispatch.sv
`default_nettype none
// ============================================================================
// tb_col_addr_dispatch : scoreboard bench with a behavioural slot model
// Revision 1.0
// ============================================================================
module tb_col_addr_dispatch;
  import col_pkg::*;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int CW = 3;

  typedef struct {
    logic [N-1:0]   v;
    logic [N*W-1:0] d;
    int             rr;
    logic           se;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  col_addr_dispatch_if #(.COL_ADDR_WIDTH(W), .NUM_CH(N), .CTRL_WIDTH(CW)) bus ();

  col_addr_dispatch #(.COL_ADDR_WIDTH(W), .NUM_CH(N), .CTRL_WIDTH(CW)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  logic [W-1:0] m_data [N];
  logic [N-1:0] m_valid;
  int           m_rr;
  logic         m_se;
  exp_t         q [$];
  int           vectors = 0;
  int           miscompares = 0;

  task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] m_packed();
    logic [N*W-1:0] p;
    for (int i = 0; i < N; i++) p[i*W +: W] = m_data[i];
    return p;
  endfunction

  function automatic bit m_free(input int i);
    return !m_valid[i] || bus.col_ack[i];
  endfunction

  function automatic bit m_ready();
    int c;
    c = int'(bus.control);
    if (rst || bus.flush) return 1'b0;
    case (bus.mode)
      MODE_DIRECT: return (c >= 1 && c <= N) ? m_free(c - 1) : 1'b1;
      MODE_RR:     return m_free(m_rr);
      MODE_BCAST: begin
        for (int i = 0; i < N; i++) if (!m_free(i)) return 1'b0;
        return 1'b1;
      end
      default:     return 1'b0;
    endcase
  endfunction

  task automatic step(input logic v, input logic [1:0] md, input int ctl, input logic [W-1:0] w,
                      input logic [N-1:0] ack, input logic fl, input logic r);
    bit   rdy, xfer, tgt, inr;
    exp_t e;
    bus.in_valid    = v;
    bus.mode        = md;
    bus.control     = CW'(ctl);
    bus.col_addr_in = w;
    bus.col_ack     = ack;
    bus.flush       = fl;
    rst             = r;
    @(negedge clk);
    check("col_valid", bus.col_valid, m_valid);
    check("rr_ptr", bus.rr_ptr, m_rr);
    check("col_addr_out", bus.col_addr_out, m_packed());
    check("sel_err", bus.sel_err, m_se);
    rdy = m_ready();
    check("in_ready", bus.in_ready, rdy);
    xfer = v && rdy;
    inr  = (ctl >= 1 && ctl <= N);
    if (r) begin
      m_valid = '0;
      for (int i = 0; i < N; i++) m_data[i] = '0;
      m_rr = 0;
      m_se = 1'b0;
    end else begin
      m_se = xfer && (md == MODE_DIRECT) && !inr;
      if (fl) begin
        m_valid = '0;
      end else begin
        for (int i = 0; i < N; i++) begin
          tgt = xfer && (((md == MODE_DIRECT) && (ctl == i + 1)) ||
                         ((md == MODE_RR) && (m_rr == i)) || (md == MODE_BCAST));
          if (tgt) begin
            m_data[i]  = w;
            m_valid[i] = 1'b1;
          end else if (ack[i]) begin
            m_valid[i] = 1'b0;
          end
        end
      end
      if (xfer && md == MODE_RR) m_rr = (m_rr + 1) % N;
    end
    if (xfer) begin
      e.v  = m_valid;
      e.d  = m_packed();
      e.rr = m_rr;
      e.se = m_se;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [N-1:0] ack);
    step(1'b0, MODE_DIRECT, 0, '0, ack, 1'b0, 1'b0);
  endtask

  // Monitor: every accepted word must match the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1 && rst === 1'b0) begin
        @(posedge clk);
        #2;
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL accept: got unexpected transfer, expected none at %0t", $time);
        end else begin
          e = q.pop_front();
          check("sb_valid", bus.col_valid, e.v);
          check("sb_data", bus.col_addr_out, e.d);
          check("sb_rr_ptr", bus.rr_ptr, e.rr);
          check("sb_sel_err", bus.sel_err, e.se);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    m_valid = '0;
    for (int i = 0; i < N; i++) m_data[i] = '0;
    m_rr = 0;
    m_se = 1'b0;
    bus.in_valid = 1'b0; bus.mode = MODE_DIRECT; bus.control = '0;
    bus.col_addr_in = '0; bus.col_ack = '0; bus.flush = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    step(1'b1, MODE_DIRECT, 3, 16'h0F0F, '0, 1'b0, 1'b1);
    step(1'b0, MODE_DIRECT, 0, '0, '0, 1'b0, 1'b1);

    // Directed target with stall until ack
    step(1'b1, MODE_DIRECT, 3, 16'hA5A5, '0, 1'b0, 1'b0);
    repeat (3) step(1'b1, MODE_DIRECT, 3, 16'h1234, '0, 1'b0, 1'b0);
    step(1'b1, MODE_DIRECT, 3, 16'h1234, 4'b0100, 1'b0, 1'b0);
    idle(4'b0100);

    // Out-of-range directed selects
    step(1'b1, MODE_DIRECT, 0, 16'h1111, '0, 1'b0, 1'b0);
    step(1'b1, MODE_DIRECT, 5, 16'h2222, '0, 1'b0, 1'b0);
    idle('0);
    idle('0);

    // Round-robin with continuous acks, then without
    for (int k = 1; k <= 6; k++) step(1'b1, MODE_RR, 0, W'(k), 4'b1111, 1'b0, 1'b0);
    idle(4'b1111);
    for (int k = 7; k <= 12; k++) step(1'b1, MODE_RR, 0, W'(k), '0, 1'b0, 1'b0);

    // Broadcast blocked by one busy slot
    idle(4'b1111);
    step(1'b1, MODE_DIRECT, 2, 16'h7777, '0, 1'b0, 1'b0);
    repeat (2) step(1'b1, MODE_BCAST, 0, 16'hBEEF, '0, 1'b0, 1'b0);
    step(1'b1, MODE_BCAST, 0, 16'hBEEF, 4'b0010, 1'b0, 1'b0);

    // Flush beats write and ack
    step(1'b1, MODE_RR, 0, 16'h9999, 4'b0001, 1'b1, 1'b0);
    idle('0);

    // Reset mid-stream with rr_ptr at 3
    step(1'b1, MODE_RR, 0, 16'h4444, 4'b1111, 1'b0, 1'b0);
    step(1'b1, MODE_RR, 0, 16'h5555, '0, 1'b0, 1'b1);
    step(1'b1, MODE_RR, 0, 16'h6666, '0, 1'b0, 1'b0);
    idle('0);

    for (int n = 0; n < 1500; n++) begin
      logic [1:0]   md;
      logic [N-1:0] ack;
      md  = ($urandom_range(0, 15) == 0) ? MODE_RSVD : 2'($urandom_range(0, 2));
      ack = ($urandom_range(0, 1) == 0) ? N'($urandom) : '0;
      step(1'($urandom), md, int'($urandom_range(0, 7)), W'($urandom), ack,
           $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
    end
    idle('0);
    idle('0);

    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL pending: got %0d unconsumed expectations, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/col_addr_dispatch.md
Name: col_addr_dispatch

Overview:
- Parametrised successor to the four-way column-address register bank.
- Steers one column-address word into one of num_ch holding slots, or into all slots, using a valid/ready handshake.
- Each slot carries a valid flag that is cleared by its consumer's ack, so no word is silently overwritten.
- Sits between the column-address generator and the per-lane convolution/PE column fetch units.

Parameters:
- col_addr_width, 2560, width of one column-address word.
- num_ch, 4, number of output slots/consumer lanes (2..16).
- ctrl_width, 3, width of the control select; must satisfy 2**ctrl_width > num_ch.

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- col_addr_in  in  col_addr_width  incoming column-address word.
- in_valid  in  1  producer has a word on col_addr_in.
- in_ready  out  1  block accepts the word this cycle; transfer when in_valid and in_ready.
- mode  in  2  0 = directed, 1 = round-robin, 2 = broadcast, 3 = reserved.
- control  in  ctrl_width  directed-mode target, 1-based (1..num_ch).
- flush  in  1  clear all slot valid flags.
- col_ack  in  num_ch  per-slot consumer ack; bit i clears slot i valid.
- col_addr_out  out  num_ch*col_addr_width  packed slot data; slot i at bits [i*W +: W].
- col_valid  out  num_ch  per-slot data-valid.
- rr_ptr  out  clog2(num_ch)  current round-robin target (0-based).
- sel_err  out  1  one-cycle pulse: directed word accepted with control 0 or control > num_ch.

Behaviour:
- Reset values:
  - col_addr_out = 0, col_valid = 0, rr_ptr = 0, sel_err = 0.
  - in_ready is 0 during the reset cycle.
- Slot i is "free" when col_valid[i] = 0 or col_ack[i] = 1 in the same cycle (ack pass-through).
- in_ready is combinational from state, mode, control, col_ack and flush. It does not depend on in_valid.
  - Directed: in_ready = free(control-1) when control is in range. When control is out of range, in_ready = 1.
  - Round-robin: in_ready = free(rr_ptr).
  - Broadcast: in_ready = all slots free.
  - Mode 3 or flush = 1: in_ready = 0.
- Latency:
  - A transfer at edge t updates the target slot(s) data and sets col_valid at t+1. That is one-cycle register latency.
  - Untargeted slots hold their data.
- Directed mode, out-of-range control: the word is accepted and discarded; no slot changes; sel_err = 1 for one cycle.
- Round-robin mode: after each transfer, rr_ptr advances to (rr_ptr+1) mod num_ch. It holds when there is no transfer. There is no skipping of busy slots; the block stalls on a busy target.
- rr_ptr keeps its value across mode changes. Only reset can change it other than a round-robin transfer.
- Ack:
  - col_ack[i] with col_valid[i] = 0 is ignored.
  - Ack and write to the same slot in the same cycle: the new data is loaded and valid stays 1.
- Flush:
  - col_valid is cleared to 0 on the next edge; data registers hold.
  - No transfer is possible in the flush cycle.
  - Flush takes priority over ack and over write.
- Data registers load only on transfer. Valid flags are the only per-slot state besides data.
- Reset mid-stream: all slots are invalidated and rr_ptr returns to 0. A word presented in the reset cycle is not accepted.

Decomposition:
- Shared package col_pkg holds:
  - the mode encodings MODE_DIRECT = 2'd0, MODE_RR = 2'd1, MODE_BCAST = 2'd2, MODE_RSVD = 2'd3;
  - the clog2 helper function.
- One sub-module, col_addr_slot: holds the data register and valid flag for one slot. Inputs are load, ack, flush, reset. Generate num_ch instances.
- Top level holds in_ready, target decode, rr_ptr and sel_err.

Test Plan:
- Test configuration for all cases: col_addr_width = 16, num_ch = 4.
1. Reset, then directed: control = 3, word 16'hA5A5.
   - Next cycle: col_valid = 4'b0100 and slot 2 = 16'hA5A5.
   - A second word to control 3 without ack: in_ready = 0 until col_ack[2] pulses.
2. Directed, control = 0 and then control = 5, words 16'h1111 and 16'h2222.
   - Each is accepted with in_ready = 1, sel_err pulses once per word, col_valid stays 4'b0000.
3. Round-robin with in_valid held high for words 1..6 and col_ack = 4'b1111 every cycle.
   - Slots receive 1, 2, 3, 4, then 5 into slot 0 and 6 into slot 1; rr_ptr ends at 2.
   - Repeat with ack low: exactly 4 accepts, then in_ready = 0.
4. Broadcast 16'hBEEF with slot 1 valid and unacked.
   - in_ready = 0.
   - Pulse col_ack[1]: in the same cycle, transfer occurs and all four slots hold 16'hBEEF with col_valid = 4'b1111.
5. With col_valid = 4'b1111, assert flush together with in_valid and col_ack[0].
   - in_ready = 0, next col_valid = 4'b0000, data unchanged.
6. Round-robin with rr_ptr = 3, then assert reset for one cycle while in_valid is high.
   - No accept occurs; all outputs are 0 after the edge; the next round-robin word lands in slot 0.
